// File: rtl/ram_req_ctrl_pkg.sv
// Shared encodings and types for the RAM request front end: access sizes,
// FSM states, and the request fields held while a response is pending.
package ram_req_ctrl_pkg;

   typedef enum logic [1:0] {
      SIZE_B    = 2'b00,
      SIZE_H    = 2'b01,
      SIZE_W    = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   typedef struct packed {
      size_e      size;
      logic       uns;
      logic [1:0] off;
      logic       we;
      logic       err;
   } req_info_t;

   // Halves ignore a[0] and words ignore a[1:0]; bytes keep the full offset.
   function automatic logic [1:0] align_off(input size_e size, input logic [1:0] off);
      logic [1:0] res;
      res = off;
      if (size == SIZE_H) res = {off[1], 1'b0};
      else if (size == SIZE_W) res = 2'b00;
      return res;
   endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Bundle of the request, response and RAM-side signals; the load/store unit
// side uses the master modport, the controller the slave modport.
interface ram_req_ctrl_if #(parameter int MEM_DEPTH = 256);
   localparam int AW = $clog2(MEM_DEPTH);

   logic          req_valid_i;
   logic          req_ready_o;
   logic [31:0]   req_addr_i;
   logic          req_we_i;
   logic [1:0]    req_size_i;
   logic          req_unsigned_i;
   logic [31:0]   req_wdata_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [31:0]   resp_rdata_o;
   logic          resp_err_o;
   logic          ram_en_o;
   logic          ram_wen_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic [3:0]    ram_wstrb_o;
   logic [31:0]   ram_rdata_i;

   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
      output resp_ready_i, ram_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  ram_en_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wstrb_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
      input  resp_ready_i, ram_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output ram_en_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wstrb_o
   );
endinterface

// File: rtl/ram_req_lane.sv
// Byte-lane datapath: store strobes and replicated write data on the way in,
// lane select plus sign/zero extension of read data on the way out.
module ram_req_lane
   import ram_req_ctrl_pkg::*;
(
   input  size_e       wr_size_i,
   input  logic [1:0]  wr_off_i,
   input  logic        wr_en_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   input  size_e       rd_size_i,
   input  logic [1:0]  rd_off_i,
   input  logic        rd_uns_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] rdata_o
);
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      wstrb_o = 4'b0000;
      wdata_o = wdata_i;
      case (wr_size_i)
         SIZE_B: begin
            wstrb_o = 4'b0001 << wr_off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SIZE_H: begin
            wstrb_o = 4'b0011 << {wr_off_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         SIZE_W:  wstrb_o = 4'b1111;
         default: wstrb_o = 4'b0000;
      endcase
      if (!wr_en_i) wstrb_o = 4'b0000;
   end

   assign rd_byte = rdata_i[{rd_off_i, 3'b000} +: 8];
   assign rd_half = rd_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      rdata_o = 32'h0;
      case (rd_size_i)
         SIZE_B:  rdata_o = {{24{~rd_uns_i & rd_byte[7]}}, rd_byte};
         SIZE_H:  rdata_o = {{16{~rd_uns_i & rd_half[15]}}, rd_half};
         SIZE_W:  rdata_o = rdata_i;
         default: rdata_o = 32'h0;
      endcase
   end
endmodule

// File: rtl/ram_req_ctrl.sv
// Single-outstanding request/response controller in front of the word RAM.
// Define RAM_REQ_CTRL_MISALIGN_CHECK_EN to flag misaligned halves/words as errors.
module ram_req_ctrl
   import ram_req_ctrl_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   ram_req_ctrl_if.slave  bus
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic [0:0]  state_q, state_d;
   req_info_t   info_q, info_d;
   size_e       req_size;
   logic [1:0]  req_off;
   logic        addr_err, size_err, mis_err, req_err;
   logic        req_hs, resp_hs, resp_valid;
   logic [31:0] lane_rdata;

   assign req_size = size_e'(bus.req_size_i);
   assign req_off  = align_off(req_size, bus.req_addr_i[1:0]);
   assign addr_err = |bus.req_addr_i[31:AW+2];
   assign size_err = (req_size == SIZE_RSVD);
`ifdef RAM_REQ_CTRL_MISALIGN_CHECK_EN
   assign mis_err  = ((req_size == SIZE_H) && bus.req_addr_i[0]) ||
                     ((req_size == SIZE_W) && (bus.req_addr_i[1:0] != 2'b00));
`else
   assign mis_err  = 1'b0;
`endif
   assign req_err  = addr_err | size_err | mis_err;

   // Ready is gated by reset because the state register alone reads IDLE then.
   assign bus.req_ready_o = rst_ni & (state_q == ST_IDLE);
   assign resp_valid      = state_q == ST_RESP;
   assign req_hs          = bus.req_valid_i & bus.req_ready_o;
   assign resp_hs         = resp_valid & bus.resp_ready_i;

   assign bus.ram_en_o   = req_hs & ~req_err;
   assign bus.ram_wen_o  = req_hs & bus.req_we_i;
   assign bus.ram_addr_o = bus.req_addr_i[AW+1:2];

   ram_req_lane u_lane (
      .wr_size_i (req_size),
      .wr_off_i  (req_off),
      .wr_en_i   (bus.ram_wen_o),
      .wdata_i   (bus.req_wdata_i),
      .wstrb_o   (bus.ram_wstrb_o),
      .wdata_o   (bus.ram_wdata_o),
      .rd_size_i (info_q.size),
      .rd_off_i  (info_q.off),
      .rd_uns_i  (info_q.uns),
      .rdata_i   (bus.ram_rdata_i),
      .rdata_o   (lane_rdata)
   );

   always_comb begin
      state_d = state_q;
      info_d  = info_q;
      case (state_q)
         ST_IDLE: if (req_hs) begin
            state_d     = ST_RESP;
            info_d.size = req_size;
            info_d.uns  = bus.req_unsigned_i;
            info_d.off  = req_off;
            info_d.we   = bus.req_we_i;
            info_d.err  = req_err;
         end
         default: if (resp_hs) state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments and cleared by the
   // async reset so a pending response is dropped the moment rst_ni falls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         info_q  <= '{size: SIZE_B, uns: 1'b0, off: 2'b00, we: 1'b0, err: 1'b0};
      end else begin
         state_q <= state_d;
         info_q  <= info_d;
      end
   end

   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_err_o   = resp_valid & info_q.err;
   assign bus.resp_rdata_o = (resp_valid && !info_q.we && !info_q.err) ? lane_rdata : 32'h0;
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural word RAM and a response
// scoreboard; honours RAM_REQ_CTRL_MISALIGN_CHECK_EN like the design.
module tb_ram_req_ctrl;
   localparam int MEM_DEPTH = 256;
   localparam int AW = $clog2(MEM_DEPTH);

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   int          checks = 0;
   int          errors = 0;
   resp_t       exp_q[$];
   logic [31:0] mem [MEM_DEPTH];
   logic [31:0] ram_rdata_q;

   ram_req_ctrl_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

   ram_req_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous RAM: byte-strobed writes, registered reads.
   always @(posedge clk_i) begin
      if (bus.ram_en_o) begin
         if (bus.ram_wen_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_wstrb_o[b]) mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
         end else begin
            ram_rdata_q <= mem[bus.ram_addr_o];
         end
      end
   end
   assign bus.ram_rdata_i = ram_rdata_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic exp_en, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
      resp_t r;
      @(negedge clk_i);
      bus.req_valid_i    = 1'b1;
      bus.req_addr_i     = addr;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_wdata_i    = wdata;
      #1;
      check({tag, ".ready"}, 32'(bus.req_ready_o), 32'd1);
      check({tag, ".ram_en"}, 32'(bus.ram_en_o), 32'(exp_en));
      if (exp_en) begin
         check({tag, ".ram_addr"}, 32'(bus.ram_addr_o), 32'(addr[AW+1:2]));
         check({tag, ".wstrb"}, 32'(bus.ram_wstrb_o), 32'(exp_strb));
         if (we) check({tag, ".wdata"}, bus.ram_wdata_o, exp_wdata);
      end
      r.rdata = exp_rdata;
      r.err   = exp_err;
      exp_q.push_back(r);
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic collect(input string tag, input int hold);
      resp_t r;
      logic  got;
      logic [31:0] held;
      check({tag, ".latency"}, 32'(bus.resp_valid_o), 32'd1);
      got = bus.resp_valid_o;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk_i);
         #1;
         got = bus.resp_valid_o;
      end
      check({tag, ".resp_seen"}, 32'(got), 32'd1);
      if (!got) return;
      check({tag, ".sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() == 0) return;
      r = exp_q.pop_front();
      held = bus.resp_rdata_o;
      if (hold > 0) begin
         bus.req_valid_i = 1'b1;
         bus.req_addr_i  = 32'h0;
         bus.req_we_i    = 1'b0;
         bus.req_size_i  = 2'b10;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         #1;
         check({tag, ".hold_valid"}, 32'(bus.resp_valid_o), 32'd1);
         check({tag, ".hold_rdata"}, bus.resp_rdata_o, held);
         check({tag, ".hold_ready"}, 32'(bus.req_ready_o), 32'd0);
         check({tag, ".hold_ram_en"}, 32'(bus.ram_en_o), 32'd0);
      end
      bus.req_valid_i = 1'b0;
      check({tag, ".rdata"}, bus.resp_rdata_o, r.rdata);
      check({tag, ".err"}, 32'(bus.resp_err_o), 32'(r.err));
      bus.resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.resp_ready_i = 1'b0;
      check({tag, ".valid_drop"}, 32'(bus.resp_valid_o), 32'd0);
      check({tag, ".ready_back"}, 32'(bus.req_ready_o), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni             = 1'b0;
      bus.req_valid_i    = 1'b1;
      bus.req_addr_i     = 32'h10;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'b10;
      bus.req_unsigned_i = 1'b0;
      bus.req_wdata_i    = 32'h0;
      bus.resp_ready_i   = 1'b0;
      #2;
      check("rst.ready", 32'(bus.req_ready_o), 32'd0);
      check("rst.valid", 32'(bus.resp_valid_o), 32'd0);
      check("rst.err", 32'(bus.resp_err_o), 32'd0);
      check("rst.rdata", bus.resp_rdata_o, 32'h0);
      check("rst.ram_en", 32'(bus.ram_en_o), 32'd0);
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("rst.ready_after", 32'(bus.req_ready_o), 32'd1);

      issue("st_w", 32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
      collect("st_w", 0);
      issue("ld_w", 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
      collect("ld_w", 0);

      issue("st_b", 32'h13, 1'b1, 2'b00, 1'b0, 32'h80, 1'b1, 4'b1000, 32'h80808080, 32'h0, 1'b0);
      collect("st_b", 0);
      issue("ld_bs", 32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0);
      collect("ld_bs", 0);
      issue("ld_bu", 32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00000080, 1'b0);
      collect("ld_bu", 0);

      issue("ld_oob", 32'h400, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      collect("ld_oob", 0);
      issue("ld_rsvd", 32'h10, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      collect("ld_rsvd", 0);
      issue("st_oob", 32'h8000_0010, 1'b1, 2'b10, 1'b0, 32'h1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      collect("st_oob", 0);

      // Word at 0x10 is now 0x80ADBEEF.
      issue("ld_h_hold", 32'h12, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF80AD, 1'b0);
      collect("ld_h_hold", 5);

`ifdef RAM_REQ_CTRL_MISALIGN_CHECK_EN
      issue("ld_h_mis", 32'h11, 1'b0, 2'b01, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
      issue("ld_h_mis", 32'h11, 1'b0, 2'b01, 1'b1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000BEEF, 1'b0);
`endif
      collect("ld_h_mis", 0);

      issue("st_h", 32'h16, 1'b1, 2'b01, 1'b0, 32'hABCD1234, 1'b1, 4'b1100, 32'h12341234, 32'h0, 1'b0);
      collect("st_h", 0);
      issue("ld_hu", 32'h16, 1'b0, 2'b01, 1'b1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00001234, 1'b0);
      collect("ld_hu", 0);
      issue("ld_b17", 32'h17, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00000012, 1'b0);
      collect("ld_b17", 0);

      // Reset while a response is pending: it must vanish, not resurface.
      issue("ld_rst", 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h80ADBEEF, 1'b0);
      @(negedge clk_i);
      #1;
      check("mid.valid_before", 32'(bus.resp_valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("mid.valid", 32'(bus.resp_valid_o), 32'd0);
      check("mid.rdata", bus.resp_rdata_o, 32'h0);
      check("mid.ready", 32'(bus.req_ready_o), 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("mid.ready_after", 32'(bus.req_ready_o), 32'd1);
      check("mid.valid_after", 32'(bus.resp_valid_o), 32'd0);
      @(negedge clk_i);
      #1;
      check("mid.no_stale", 32'(bus.resp_valid_o), 32'd0);

      issue("ld_post", 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h80ADBEEF, 1'b0);
      collect("ld_post", 0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
